// File: rtl/sar_seq_avg.sv
// Conversion sequencer and result averager for a 7-bit SAR conversion FSM.
// Paces SOC, captures results on EOC, and emits the truncated mean of 2^AVG_LOG2 samples.
module sar_seq_avg #(
    parameter int DW       = 7,
    parameter int AVG_LOG2 = 2,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                soc,
    input  logic                eoc,
    input  logic [DW-1:0]       q_in,
    output logic [DW-1:0]       avg_data,
    output logic                avg_valid,
    input  logic                avg_ready,
    output logic                overrun,
    output logic                timeout_err,
    input  logic                clear_err
);

    localparam int ACC_W = DW + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_EOC = 2'd1,
        CAPTURE  = 2'd2,
        HOLDOFF  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                soc_q, soc_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PERIOD_W-1:0] hold_q, hold_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DW-1:0]       avg_data_q, avg_data_d;
    logic                avg_valid_q, avg_valid_d;
    logic                overrun_q, overrun_d;
    logic                timeout_err_q, timeout_err_d;

    logic [ACC_W-1:0]    acc_sum;
    logic [PERIOD_W-1:0] hold_load;
    logic                avg_load;
    logic                tmo_hit;

    assign hold_load = (period == '0) ? PERIOD_W'(1) : period;
    assign acc_sum   = acc_q + ACC_W'(q_in);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            soc_q         <= 1'b1;
            acc_q         <= '0;
            cnt_q         <= '0;
            hold_q        <= '0;
            tmo_q         <= '0;
            avg_data_q    <= '0;
            avg_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            soc_q         <= soc_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            tmo_q         <= tmo_d;
            avg_data_q    <= avg_data_d;
            avg_valid_q   <= avg_valid_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (enable) state_d = WAIT_EOC;
            WAIT_EOC: begin
                if (eoc)                    state_d = CAPTURE;
                else if (tmo_q == TMO_LAST) state_d = HOLDOFF;
            end
            CAPTURE:  state_d = HOLDOFF;
            HOLDOFF:  if (hold_q <= PERIOD_W'(1)) state_d = enable ? WAIT_EOC : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        tmo_d    = '0;
        avg_load = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
            end
            WAIT_EOC: begin
                if (!eoc) begin
                    if (tmo_q == TMO_LAST) begin
                        // A failed conversion poisons the running group, so it is dropped.
                        tmo_hit = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        hold_d  = hold_load;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                hold_d = hold_load;
                if (cnt_q == CNT_LAST) begin
                    avg_load = 1'b1;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLDOFF: if (hold_q != '0) hold_d = hold_q - 1'b1;
            default: ;
        endcase

        avg_data_d    = avg_load ? DW'(acc_sum >> AVG_LOG2) : avg_data_q;
        avg_valid_d   = avg_load | (avg_valid_q & ~avg_ready);
        // Flag sets take priority over a simultaneous clear_err.
        overrun_d     = (avg_load & avg_valid_q & ~avg_ready) | (overrun_q & ~clear_err);
        timeout_err_d = tmo_hit | (timeout_err_q & ~clear_err);
        soc_d         = (state_d != WAIT_EOC);
    end

    assign soc         = soc_q;
    assign avg_data    = avg_data_q;
    assign avg_valid   = avg_valid_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sar_seq_avg.sv
// Self-checking bench for sar_seq_avg: behavioural SAR eoc model, random samples,
// expected means computed as plain sum/count arithmetic.
module tb_sar_seq_avg;

    localparam int DW = 7;

    logic          clk = 1'b0;
    logic          rst_n, enable, avg_ready, clear_err;
    logic [15:0]   period;
    logic          soc, avg_valid, overrun, timeout_err;
    logic          eoc = 1'b0;
    logic [DW-1:0] q_in = '0;
    logic [DW-1:0] avg_data;

    logic          enable0;
    logic [15:0]   period0;
    logic          soc0, avg_valid0, overrun0, timeout_err0;
    logic          eoc0 = 1'b0;
    logic [DW-1:0] q_in0, avg_data0;

    int            n_cmp = 0;
    int            n_err = 0;
    logic          eoc_block = 1'b0;
    logic [DW-1:0] samp_q[$];
    logic [DW-1:0] words[$];
    logic [DW-1:0] words0[$];
    int            fall_cyc[$];
    int            cyc = 0;
    logic          soc_prev = 1'b1;
    int            sar_cnt = 0;
    int            sar_cnt0 = 0;

    always #5 clk = ~clk;

    sar_seq_avg #(.DW(7), .AVG_LOG2(2), .PERIOD_W(16), .TIMEOUT(31)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .soc(soc),
        .eoc(eoc), .q_in(q_in), .avg_data(avg_data), .avg_valid(avg_valid),
        .avg_ready(avg_ready), .overrun(overrun), .timeout_err(timeout_err),
        .clear_err(clear_err)
    );

    sar_seq_avg #(.DW(7), .AVG_LOG2(0), .PERIOD_W(16), .TIMEOUT(31)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable0), .period(period0), .soc(soc0),
        .eoc(eoc0), .q_in(q_in0), .avg_data(avg_data0), .avg_valid(avg_valid0),
        .avg_ready(1'b1), .overrun(overrun0), .timeout_err(timeout_err0),
        .clear_err(1'b0)
    );

    // SAR converter model: eoc rises 9 cycles after soc falls; soc high resets it.
    always @(posedge clk) begin
        if (soc) begin
            sar_cnt <= 0;
            eoc     <= 1'b0;
        end else begin
            sar_cnt <= sar_cnt + 1;
            if (sar_cnt + 1 >= 9 && !eoc && !eoc_block) begin
                eoc <= 1'b1;
                if (samp_q.size() > 0) q_in <= samp_q.pop_front();
            end
        end
    end

    always @(posedge clk) begin
        if (soc0) begin
            sar_cnt0 <= 0;
            eoc0     <= 1'b0;
        end else begin
            sar_cnt0 <= sar_cnt0 + 1;
            if (sar_cnt0 + 1 >= 9) eoc0 <= 1'b1;
        end
    end

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        soc_prev <= soc;
        if (!soc && soc_prev) fall_cyc.push_back(cyc);
        if (rst_n && avg_valid && avg_ready) words.push_back(avg_data);
        if (rst_n && avg_valid0) words0.push_back(avg_data0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(int i);
        return (words.size() > i) ? 32'(words[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] fall_gap(int i);
        return (fall_cyc.size() > i) ? 32'(fall_cyc[i] - fall_cyc[i-1]) : 32'hFFFF_FFFF;
    endfunction

    task automatic push_samples(input int n, input int fixed, output int sum);
        sum = 0;
        for (int i = 0; i < n; i++) begin
            int v;
            v = (fixed >= 0) ? fixed : int'($urandom_range(0, 127));
            samp_q.push_back(DW'(v));
            sum += v;
        end
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (samp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(samp_q.size() == 0), 32'd1);
    endtask

    task automatic wait_soc(input logic v, input string tag);
        int n;
        n = 0;
        while (soc !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_soc_wait"}, 32'(soc), 32'(v));
    endtask

    // Run one burst: samples already queued, enable dropped during the last WAIT_EOC.
    task automatic run_burst(input string tag);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_empty(tag);
        enable = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int s1, s2, s3, p, pm, bad, n, dummy;
        int pchoice[4];
        logic [DW-1:0] r;

        rst_n = 1'b0; enable = 1'b0; avg_ready = 1'b1; clear_err = 1'b0; period = 16'd3;
        enable0 = 1'b0; period0 = 16'd3; q_in0 = 7'd5;
        pchoice = '{0, 1, 2, 5};
        #12;
        check("rst_soc", 32'(soc), 32'd1);
        check("rst_valid", 32'(avg_valid), 32'd0);
        check("rst_data", 32'(avg_data), 32'd0);
        check("rst_flags", {30'd0, overrun, timeout_err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (soc !== 1'b1 || avg_valid !== 1'b0 || overrun !== 1'b0 || timeout_err !== 1'b0) bad++;
        end
        check("idle20_bad_cycles", 32'(bad), 32'd0);

        // Basic four-sample average and 14-cycle pacing with period = 3.
        words.delete(); fall_cyc.delete();
        samp_q.push_back(7'd10); samp_q.push_back(7'd11);
        samp_q.push_back(7'd12); samp_q.push_back(7'd14);
        run_burst("p1");
        check("p1_nwords", 32'(words.size()), 32'd1);
        check("p1_avg", word_at(0), 32'd11);
        for (int i = 1; i < 4; i++) check("p1_gap", fall_gap(i), 32'd14);
        check("p1_idle_soc", 32'(soc), 32'd1);

        // Full-scale group then two random groups, random period (0 acts as 1).
        p = pchoice[$urandom_range(0, 3)];
        pm = (p == 0) ? 1 : p;
        period = 16'(p);
        words.delete(); fall_cyc.delete();
        push_samples(4, 127, s1);
        push_samples(4, -1, s2);
        push_samples(4, -1, s3);
        run_burst("p2");
        check("p2_nwords", 32'(words.size()), 32'd3);
        check("p2_avg_max", word_at(0), 32'(s1 / 4));
        check("p2_avg_r1", word_at(1), 32'(s2 / 4));
        check("p2_avg_r2", word_at(2), 32'(s3 / 4));
        check("p2_gap_in_group", fall_gap(1), 32'(11 + pm));
        check("p2_gap_after_load", fall_gap(4), 32'(11 + pm));

        // Overrun: two averages with nobody consuming.
        period = 16'd2; avg_ready = 1'b0;
        words.delete();
        push_samples(4, -1, s1);
        push_samples(4, -1, s2);
        run_burst("p3");
        check("p3_valid", 32'(avg_valid), 32'd1);
        check("p3_data_second", 32'(avg_data), 32'(s2 / 4));
        check("p3_overrun", 32'(overrun), 32'd1);
        check("p3_nwords", 32'(words.size()), 32'd0);
        @(posedge clk); #1 clear_err = 1'b1;
        @(posedge clk); #1 clear_err = 1'b0;
        check("p3_overrun_cleared", 32'(overrun), 32'd0);
        check("p3_valid_kept", 32'(avg_valid), 32'd1);

        // Consume and load in the same cycle.
        push_samples(4, -1, s3);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_empty("p3b");
        enable = 1'b0;
        wait_soc(1'b1, "p3b_capture");
        #1 avg_ready = 1'b1;
        @(negedge clk);
        check("p3b_valid_stays", 32'(avg_valid), 32'd1);
        check("p3b_data_new", 32'(avg_data), 32'(s3 / 4));
        check("p3b_no_overrun", 32'(overrun), 32'd0);
        repeat (30) @(negedge clk);
        check("p3b_nwords", 32'(words.size()), 32'd1);
        check("p3b_word", word_at(0), 32'(s3 / 4));
        check("p3b_valid_done", 32'(avg_valid), 32'd0);

        // Timeout after two good samples; partial group must be dropped.
        period = 16'd3;
        words.delete();
        push_samples(2, -1, dummy);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_empty("p4");
        eoc_block = 1'b1;
        wait_soc(1'b1, "p4_capture");
        wait_soc(1'b0, "p4_wait");
        n = 0;
        while (soc === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("p4_wait_len", 32'(n), 32'd31);
        check("p4_timeout_err", 32'(timeout_err), 32'd1);
        eoc_block = 1'b0;
        push_samples(4, -1, s1);
        wait_empty("p4b");
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check("p4_nwords", 32'(words.size()), 32'd1);
        check("p4_avg_fresh", word_at(0), 32'(s1 / 4));
        @(posedge clk); #1 clear_err = 1'b1;
        @(posedge clk); #1 clear_err = 1'b0;
        check("p4_timeout_cleared", 32'(timeout_err), 32'd0);

        // enable dropped after two captured samples, during the third conversion.
        period = 16'd1;
        words.delete();
        push_samples(3, -1, dummy);
        run_burst("p5");
        check("p5_nwords", 32'(words.size()), 32'd0);
        check("p5_idle_soc", 32'(soc), 32'd1);
        push_samples(4, -1, s1);
        run_burst("p5b");
        check("p5b_nwords", 32'(words.size()), 32'd1);
        check("p5b_avg", word_at(0), 32'(s1 / 4));

        // Reset pulse while in CAPTURE of the group's last sample.
        words.delete();
        push_samples(4, -1, dummy);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_empty("p6");
        enable = 1'b0;
        wait_soc(1'b1, "p6_capture");
        #1 rst_n = 1'b0;
        #1;
        check("p6_rst_soc", 32'(soc), 32'd1);
        check("p6_rst_valid", 32'(avg_valid), 32'd0);
        check("p6_rst_data", 32'(avg_data), 32'd0);
        check("p6_rst_flags", {30'd0, overrun, timeout_err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("p6_nwords", 32'(words.size()), 32'd0);
        push_samples(4, -1, s1);
        run_burst("p6b");
        check("p6b_avg", word_at(0), 32'(s1 / 4));

        // Pass-through build: every conversion yields its own sample.
        for (int k = 0; k < 2; k++) begin
            r = (k == 0) ? 7'd5 : 7'($urandom_range(0, 127));
            q_in0 = r;
            words0.delete();
            @(posedge clk);
            #1 enable0 = 1'b1;
            n = 0;
            while (words0.size() < 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
            #1 enable0 = 1'b0;
            check("p7_nwords", 32'(words0.size() >= 3), 32'd1);
            for (int i = 0; i < 3; i++)
                check("p7_word", (words0.size() > i) ? 32'(words0[i]) : 32'hFFFF_FFFF, 32'(r));
            repeat (30) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
